// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and instruction buffer bus for the fetch stage
//
// Purpose: groups the instruction-memory request/response handshake and the
// instruction-buffer write port into one bundle.
// Signals:
//   imem_req/imem_addr      request valid and word address (fetch -> memory)
//   imem_ready              memory accepts the request this cycle
//   imem_rvalid/imem_rdata  response valid and instruction word (memory -> fetch)
//   ins_full                instruction buffer full (buffer -> fetch)
//   wr_en/pc_out/next_pc_out/instruction_out  buffer write port (fetch -> buffer)
//   ins_flush               one-cycle buffer flush pulse (fetch -> buffer)
// Modports: master = fetch unit side, slave = memory/buffer side.

interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ins_full;
    logic        wr_en;
    logic [31:0] pc_out;
    logic [31:0] next_pc_out;
    logic [31:0] instruction_out;
    logic        ins_flush;

    modport master (
        output imem_req, imem_addr, wr_en, pc_out, next_pc_out, instruction_out, ins_flush,
        input  imem_ready, imem_rvalid, imem_rdata, ins_full
    );

    modport slave (
        input  imem_req, imem_addr, wr_en, pc_out, next_pc_out, instruction_out, ins_flush,
        output imem_ready, imem_rvalid, imem_rdata, ins_full
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with JAL predecode and redirect handling
//
// Purpose: owns the fetch PC, issues single-outstanding word requests to
// instruction memory and writes each returned instruction into the
// instruction buffer with its PC and predicted next PC. JAL is predicted
// taken; everything else falls through to pc+4. A redirect reloads the PC,
// pulses ins_flush and squashes any outstanding response.
// Ports:
//   clk             clock, rising edge
//   reset           synchronous, active-high
//   redirect_valid  single-cycle redirect pulse from the branch unit
//   redirect_pc     redirect target (bits [1:0] ignored)
//   bus             fetch_unit_if.master: imem handshake and buffer write port

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    fetch_unit_if.master      bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [29:0] fpc;
    logic [29:0] fpc_n;
    logic        ins_flush_q;
    logic [31:0] pc_full;
    logic [31:0] jal_imm;
    logic [31:0] pred_pc;
    logic        is_jal;
    logic        unused_redirect_low;

    // Word-aligned PC: the two low bits are never stored.
    assign pc_full             = {fpc, 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];

    // Predecode: J-type immediate of a JAL, sign-extended to 32 bits.
    assign is_jal  = (bus.imem_rdata[6:0] == 7'b1101111);
    assign jal_imm = {{11{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[19:12],
                      bus.imem_rdata[20], bus.imem_rdata[30:21], 1'b0};
    assign pred_pc = is_jal ? (pc_full + jal_imm) : (pc_full + 32'd4);

    assign bus.imem_addr       = pc_full;
    assign bus.pc_out          = pc_full;
    assign bus.next_pc_out     = pred_pc;
    assign bus.instruction_out = bus.imem_rdata;
    assign bus.ins_flush       = ins_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            fpc         <= RESET_PC[31:2];
            ins_flush_q <= 1'b0;
        end else begin
            state       <= state_n;
            fpc         <= fpc_n;
            ins_flush_q <= redirect_valid;
        end
    end

    always_comb begin
        state_n      = state;
        fpc_n        = fpc;
        bus.imem_req = 1'b0;
        bus.wr_en    = 1'b0;

        case (state)
            FETCH: begin
                // Requests are suppressed while the buffer is full, during the
                // flush cycle and in a redirect cycle, so a redirect never
                // coincides with an accepted request.
                bus.imem_req = !reset && !bus.ins_full && !ins_flush_q && !redirect_valid;
                if (bus.imem_req && bus.imem_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_n = FETCH;
                    if (!redirect_valid && !reset) begin
                        bus.wr_en = 1'b1;
                        fpc_n     = pred_pc[31:2];
                    end
                end else if (redirect_valid) begin
                    // Response still in flight belongs to the squashed path.
                    state_n = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        if (redirect_valid) begin
            fpc_n = redirect_pc[31:2];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard testbench for fetch_unit

module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    int          checks;
    int          failures;
    int          cyc;
    int          last_wr;
    int          w;
    logic [95:0] sb[$];

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a request, checks its address, optionally stalls
    // with imem_ready low, then lets it be accepted. Returns just after the
    // accepting edge.
    task automatic accept(input logic [31:0] addr, input int stall, output int waited);
        int n;
        n = 0;
        bus.imem_ready = (stall == 0);
        @(negedge clk);
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        check("req_seen", bus.imem_req, 1'b1);
        check("req_addr", bus.imem_addr, addr);
        for (int i = 0; i < stall; i++) begin
            step();
            if (i == stall - 1) bus.imem_ready = 1'b1;
            @(negedge clk);
            check("stall_req", bus.imem_req, 1'b1);
            check("stall_addr", bus.imem_addr, addr);
        end
        step();
    endtask

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] nxt, input int lat, input int stall,
                             output int waited);
        logic [95:0] e;
        accept(addr, stall, waited);
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            check("wait_no_wr", bus.wr_en, 1'b0);
            step();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = instr;
        sb.push_back({addr, nxt, instr});
        @(negedge clk);
        check("wr_en", bus.wr_en, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc_out", bus.pc_out, e[95:64]);
            check("next_pc_out", bus.next_pc_out, e[63:32]);
            check("instruction_out", bus.instruction_out, e[31:0]);
        end
        last_wr = cyc;
        step();
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic redirect_pulse(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        check("redir_no_req", bus.imem_req, 1'b0);
        check("redir_no_wr", bus.wr_en, 1'b0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("flush_pulse", bus.ins_flush, 1'b1);
        check("flush_no_req", bus.imem_req, 1'b0);
        check("flush_no_wr", bus.wr_en, 1'b0);
        step();
    endtask

    initial begin
        int prev;
        checks          = 0;
        failures        = 0;
        last_wr         = 0;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.ins_full    = 1'b0;

        // Reset state.
        repeat (3) step();
        @(negedge clk);
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_wr", bus.wr_en, 1'b0);
        check("rst_flush", bus.ins_flush, 1'b0);
        step();
        reset = 1'b0;

        // Four sequential NOPs, one write every two cycles.
        fetch_one(32'h100, NOP, 32'h104, 1, 0, w);
        check("first_req_latency", w, 0);
        for (int i = 1; i < 4; i++) begin
            prev = last_wr;
            fetch_one(32'h100 + 4 * i, NOP, 32'h104 + 4 * i, 1, 0, w);
            check("nop_req_latency", w, 0);
            check("write_spacing", last_wr - prev, 2);
        end

        // JAL prediction forward and backward.
        redirect_pulse(32'h200);
        fetch_one(32'h200, 32'h0100_006F, 32'h210, 1, 0, w);
        check("redir_req_latency", w, 0);
        fetch_one(32'h210, 32'hFF9F_F06F, 32'h208, 1, 0, w);
        fetch_one(32'h208, NOP, 32'h20C, 2, 3, w);

        // Backpressure holds requests off at an unchanged PC.
        bus.ins_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_no_req", bus.imem_req, 1'b0);
            step();
        end
        bus.ins_full = 1'b0;
        fetch_one(32'h20C, NOP, 32'h210, 1, 0, w);
        check("release_latency", w, 0);

        // Redirect while waiting on a slow response: stale response dropped.
        accept(32'h210, 0, w);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h403;
        @(negedge clk);
        check("wait_redir_no_wr", bus.wr_en, 1'b0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wait_redir_flush", bus.ins_flush, 1'b1);
        check("wait_redir_no_req", bus.imem_req, 1'b0);
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = NOP;
        @(negedge clk);
        check("stale_no_wr", bus.wr_en, 1'b0);
        check("stale_no_req", bus.imem_req, 1'b0);
        check("flush_once", bus.ins_flush, 1'b0);
        step();
        bus.imem_rvalid = 1'b0;
        fetch_one(32'h400, NOP, 32'h404, 1, 0, w);
        check("drop_exit_latency", w, 0);

        // Redirect coinciding with the response.
        accept(32'h404, 0, w);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = NOP;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h500;
        @(negedge clk);
        check("same_cycle_no_wr", bus.wr_en, 1'b0);
        step();
        bus.imem_rvalid = 1'b0;
        redirect_valid  = 1'b0;
        @(negedge clk);
        check("same_cycle_flush", bus.ins_flush, 1'b1);
        check("same_cycle_no_req", bus.imem_req, 1'b0);
        step();

        // Second redirect while in DROP: latest target wins, one discard.
        accept(32'h500, 0, w);
        check("after_same_cycle_latency", w, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h600;
        @(negedge clk);
        check("drop1_no_wr", bus.wr_en, 1'b0);
        step();
        redirect_pc = 32'h700;
        @(negedge clk);
        check("drop2_no_req", bus.imem_req, 1'b0);
        step();
        redirect_valid  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = NOP;
        @(negedge clk);
        check("drop_discard_no_wr", bus.wr_en, 1'b0);
        check("drop_discard_flush", bus.ins_flush, 1'b1);
        step();
        bus.imem_rvalid = 1'b0;
        fetch_one(32'h700, NOP, 32'h704, 1, 0, w);
        check("latest_target_latency", w, 0);

        // Wrap at the top of the address space.
        redirect_pulse(32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, NOP, 32'h0, 1, 0, w);

        // Reset while waiting; response during reset is ignored.
        accept(32'h0, 0, w);
        check("wrap_req_latency", w, 0);
        reset           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = NOP;
        @(negedge clk);
        check("rst_wait_no_wr", bus.wr_en, 1'b0);
        check("rst_wait_no_req", bus.imem_req, 1'b0);
        step();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        check("rst_after_req", bus.imem_req, 1'b0);
        check("rst_after_wr", bus.wr_en, 1'b0);
        check("rst_after_flush", bus.ins_flush, 1'b0);
        step();
        reset = 1'b0;
        fetch_one(32'h100, NOP, 32'h104, 1, 0, w);
        check("restart_latency", w, 0);

        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
